// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, counter-based debounce FSM,
// press/release/long-press pulses, captured long flag and wrapping press count.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic       o_was_long,
  output logic [7:0] o_count
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              s1_q, s2_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_flag_q, long_flag_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              was_long_q, was_long_d;
  logic [7:0]        count_q, count_d;

  logic              pressed;
  logic [HOLD_W-1:0] hold_inc;

  assign pressed  = s2_q ^ ACTIVE_LOW;
  assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;

  // Synchronizer resets to the released pin level so leaving reset is quiet.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_q        <= ACTIVE_LOW;
      s2_q        <= ACTIVE_LOW;
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      was_long_q  <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      s1_q        <= i_btn;
      s2_q        <= s1_q;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      was_long_q  <= was_long_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    was_long_d  = was_long_q;
    count_d     = count_q;

    unique case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d     = HELD;
          press_d     = 1'b1;
          level_d     = 1'b1;
          count_d     = count_q + 8'd1;
          hold_cnt_d  = '0;
          long_flag_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      HELD: begin
        hold_cnt_d = hold_inc;
        // Long check runs only here, including the edge that leaves for RELEASE_WAIT.
        if (!long_flag_q && (hold_cnt_q == HOLD_MAX)) begin
          long_d      = 1'b1;
          long_flag_d = 1'b1;
        end
        if (!pressed) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        hold_cnt_d = hold_inc;
        if (pressed) begin
          state_d = HELD;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d    = IDLE;
          release_d  = 1'b1;
          level_d    = 1'b0;
          was_long_d = long_flag_q;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_level    = level_q;
  assign o_press    = press_q;
  assign o_release  = release_q;
  assign o_long     = long_q;
  assign o_was_long = was_long_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random button activity,
// checked every cycle against a run-length reference model.
module tb_button_debounce;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       level, press, release_p, long_p, was_long;
  logic [7:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_btn     (btn),
    .o_level   (level),
    .o_press   (press),
    .o_release (release_p),
    .o_long    (long_p),
    .o_was_long(was_long),
    .o_count   (count)
  );

  // Reference: the level flips after DEB+1 consecutive opposite samples;
  // hold time counts edges since the press was accepted.
  bit m_sync1 = 0, m_sync2 = 0;
  bit m_level = 0, m_long_flag = 0, m_was_long = 0;
  bit e_press = 0, e_release = 0, e_long = 0;
  int m_opp_run = 0, m_hold = 0, m_count = 0;

  always @(posedge clk) begin
    bit p_now;
    e_press   = 0;
    e_release = 0;
    e_long    = 0;
    if (!rst_n) begin
      m_sync1 = 0; m_sync2 = 0; m_level = 0; m_long_flag = 0; m_was_long = 0;
      m_opp_run = 0; m_hold = 0; m_count = 0;
    end else begin
      p_now   = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = ~btn;
      if (m_level) begin
        // fully held (no release candidate pending) and held long enough
        if (!m_long_flag && m_opp_run == 0 && m_hold == LNG - 1) begin
          e_long      = 1;
          m_long_flag = 1;
        end
        if (m_hold < LNG - 1) m_hold++;
      end
      m_opp_run = (p_now != m_level) ? m_opp_run + 1 : 0;
      if (m_opp_run == DEB + 1) begin
        m_opp_run = 0;
        m_level   = ~m_level;
        if (m_level) begin
          e_press     = 1;
          m_count     = (m_count + 1) % 256;
          m_hold      = 0;
          m_long_flag = 0;
        end else begin
          e_release  = 1;
          m_was_long = m_long_flag;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Compare outputs of the last edge, then apply inputs for the next edge.
  task automatic cycle(input logic b, input logic r);
    @(negedge clk);
    check_eq("level",    int'(level),     int'(m_level));
    check_eq("press",    int'(press),     int'(e_press));
    check_eq("release",  int'(release_p), int'(e_release));
    check_eq("long",     int'(long_p),    int'(e_long));
    check_eq("was_long", int'(was_long),  int'(m_was_long));
    check_eq("count",    int'(count),     m_count);
    btn   = b;
    rst_n = r;
  endtask

  initial begin
    int lvl, len;
    rst_n = 1'b0;
    btn   = 1'b1;

    // reset, then quiet idle
    repeat (3) cycle(1'b1, 1'b0);
    repeat (50) cycle(1'b1, 1'b1);

    // clean short press
    repeat (10) cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b1, 1'b1);

    // bounce: runs of at most 3 pressed samples never qualify
    repeat (20) begin
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);
    end
    repeat (10) cycle(1'b1, 1'b1);
    check_eq("bounce_count", int'(count), 1);

    // long press
    repeat (30) cycle(1'b0, 1'b1);
    repeat (15) cycle(1'b1, 1'b1);
    check_eq("long_was_long", int'(was_long), 1);

    // release bounce while held
    repeat (8) cycle(1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b1);
    repeat (20) cycle(1'b0, 1'b1);
    repeat (15) cycle(1'b1, 1'b1);

    // 256 clean presses wrap the count back to its prior value
    repeat (256) begin
      repeat (7) cycle(1'b0, 1'b1);
      repeat (8) cycle(1'b1, 1'b1);
    end
    check_eq("wrap_count", int'(count), 3);

    // reset while held
    repeat (10) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1);
    repeat (15) cycle(1'b1, 1'b1);

    // random activity with short glitches and occasional resets
    repeat (400) begin
      lvl = $urandom_range(0, 1);
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 20);
      repeat (len) cycle(1'(lvl), ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end
    repeat (20) cycle(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounced pushbutton input conditioner; the input-side counterpart of the LED output path. It synchronizes a raw board button to `i_clk` and filters contact bounce with a counter-based state machine. It produces a clean level, single-cycle press and release pulses, a long-press pulse, and a wrapping press count. It sits between a board pin and user logic such as mode selection or counter reset.

## Interface
- `DEBOUNCE_CYCLES`, 120000 — consecutive stable cycles required to accept a press or release; 10 ms at 12 MHz; must be ≥ 2.
- `LONG_CYCLES`, 12000000 — cycles a debounced press must be held before `o_long` fires; 1 s at 12 MHz; must be ≥ 2.
- `ACTIVE_LOW`, 1 — 1: `i_btn` == 0 means pressed; 0: `i_btn` == 1 means pressed.
- `i_clk` in 1 — sole clock; every flop is rising-edge.
- `i_rst_n` in 1 — reset, synchronous and active-low; sampled on the `i_clk` rising edge.
- `i_btn` in 1 — raw asynchronous button pin.
- `o_level` out 1 — debounced pressed level; 1 = pressed.
- `o_press` out 1 — one-cycle pulse on an accepted press.
- `o_release` out 1 — one-cycle pulse on an accepted release.
- `o_long` out 1 — one-cycle pulse when a press has been held `LONG_CYCLES`; at most once per press.
- `o_was_long` out 1 — captured on each accepted release; 1 if that press produced `o_long`. Holds until the next release.
- `o_count` out 8 — number of accepted presses, mod 256.

## Operation
- **Synchronizer:** 2-flop synchronizer `s1` → `s2`. Define `p = s2 ^ ACTIVE_LOW`, so `p` = 1 means pressed. No logic reads `i_btn` or `s1` directly.
- **Counters:**
  - `deb_cnt` is wide enough for `DEBOUNCE_CYCLES-1`.
  - `hold_cnt` is wide enough for `LONG_CYCLES-1` and saturates at `LONG_CYCLES-1`.
  - `long_flag` is 1 bit.
- **Reset:**
  - `s1` and `s2` load the released pin level (`ACTIVE_LOW`), so leaving reset never creates a spurious press.
  - State = IDLE; all counters, `long_flag` and every output = 0.
- **IDLE** (stable released):
  - `p` = 1 → PRESS_WAIT, `deb_cnt` ← 0.
- **PRESS_WAIT:**
  - `p` = 0 → IDLE. No event is produced; this is bounce rejection.
  - `p` = 1 and `deb_cnt` == `DEBOUNCE_CYCLES-1` → HELD. Pulse `o_press`, set `o_level` ← 1, increment `o_count` (255 wraps to 0), `hold_cnt` ← 0, `long_flag` ← 0.
  - Otherwise `deb_cnt` += 1.
- **HELD:**
  - `hold_cnt` increments, saturating.
  - If `long_flag` == 0 and `hold_cnt` == `LONG_CYCLES-1`: pulse `o_long`, `long_flag` ← 1. This check happens only in HELD.
  - `p` = 0 → RELEASE_WAIT, `deb_cnt` ← 0. The long check still applies on that same edge.
- **RELEASE_WAIT:**
  - `hold_cnt` keeps incrementing, saturating; `o_level` stays 1.
  - `p` = 1 → HELD; `hold_cnt` and `long_flag` are preserved.
  - `p` = 0 and `deb_cnt` == `DEBOUNCE_CYCLES-1` → IDLE. Pulse `o_release`, set `o_level` ← 0, `o_was_long` ← `long_flag`.
  - Otherwise `deb_cnt` += 1.
- **Pulse and output encoding:**
  - `o_press`, `o_release` and `o_long` are registered and default to 0 every cycle.
  - `o_press` and `o_long` can never coincide, because `o_long` needs at least 2 cycles in HELD.
- **Reset mid-operation:** an active reset on any edge overrides every transition. No release pulse is emitted for a press that was in progress.

## Timing
- Edge numbering: `i_btn` goes to pressed between edge 0 and edge 1.
  - `s2` is pressed after edge 2.
  - Edge 3: IDLE → PRESS_WAIT.
  - Edge `DEBOUNCE_CYCLES+3`: enter HELD; `o_press` and `o_level` go high after this edge.
- Press latency is `DEBOUNCE_CYCLES+3` cycles, provided `i_btn` is stable throughout.
- `o_long` goes high after edge `DEBOUNCE_CYCLES+3+LONG_CYCLES`, if the button is held continuously.
- Release latency is symmetric: `o_release` goes high after edge `DEBOUNCE_CYCLES+3`, counted from the release change.
- Any opposite-level sample on `p` in PRESS_WAIT or RELEASE_WAIT restarts the debounce from scratch. The debounce window only resets; it never accumulates across glitches.
- Pulses last exactly 1 cycle.
- `o_level`, `o_count` and `o_was_long` change only on the same edge as their associated pulse.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `ACTIVE_LOW`=1.

1. **Reset:** hold `i_rst_n`=0 for 3 edges with `i_btn`=1, then release reset → every output 0; no pulse for 50 cycles.
2. **Clean short press:** `i_btn`=0 from edge 0 for 10 cycles, then 1.
   - `o_press` high after edge 7 only; `o_level` 1 from edge 7; `o_count`=1.
   - `o_release` pulses 7 edges after the release change; `o_was_long`=0; `o_long` never fires.
3. **Bounce rejection:** `i_btn` pattern 0,0,1,0,0,1,… with no run of 0 longer than 3 cycles, followed by idle → no `o_press`, `o_count` stays 0.
4. **Long press:** `i_btn`=0 for 30 cycles.
   - `o_press` after edge 7; `o_long` after edge 17, exactly once.
   - After release: `o_release` pulses and `o_was_long`=1.
5. **Release bounce:** while HELD, drive `i_btn`=1 for 2 cycles, then 0 → no `o_release`; `o_level` stays 1; `o_long` still fires at edge 17.
6. **Wrap and mid-reset:**
   - Perform 256 clean presses → `o_count` returns to 0.
   - Assert `i_rst_n`=0 during HELD → next edge gives IDLE with all outputs 0 and no `o_release`.
